// File: rtl/strait_pe_ws.sv
// Weight-stationary systolic PE: double-buffered weight preload, valid-tagged MAC,
// fault bypass and a built-in self-test that folds a pattern sweep into a signature.
module strait_pe_ws #(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int SIGNED            = 0,
    parameter int TEST_LEN          = 16,
    parameter logic [PARTIAL_SUM_WIDTH-1:0] GOLDEN_SIG = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WEIGHT_WIDTH-1:0]      weight_in,
    input  logic                         weight_shift_en,
    input  logic                         weight_commit,
    output logic [WEIGHT_WIDTH-1:0]      weight_out,
    input  logic [ACTIVATION_WIDTH-1:0]  activation,
    input  logic                         act_valid_in,
    output logic [ACTIVATION_WIDTH-1:0]  activation_out,
    output logic                         act_valid_out,
    input  logic [PARTIAL_SUM_WIDTH-1:0] partial_sum_in,
    output logic [PARTIAL_SUM_WIDTH-1:0] partial_sum_out,
    output logic                         psum_valid_out,
    input  logic                         fault_bypass,
    input  logic                         test_start,
    input  logic                         test_fault_inj,
    output logic                         test_busy,
    output logic                         test_done,
    output logic                         test_fail
);

    localparam int P     = PARTIAL_SUM_WIDTH;
    localparam int CNT_W = $clog2(TEST_LEN);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [P-1:0]                sig_q;
    logic                        busy_q, done_q, fail_q;

    logic [WEIGHT_WIDTH-1:0]     shadow_q, active_q;
    logic [ACTIVATION_WIDTH-1:0] act_q;
    logic                        avld_q, pvld_q;
    logic [P-1:0]                psum_q;

    logic [WEIGHT_WIDTH-1:0]     w_sel;
    logic [ACTIVATION_WIDTH-1:0] a_sel;
    logic [P-1:0]                ps_sel, mac_d, fold_d;

    function automatic logic [P-1:0] ext_w(input logic [WEIGHT_WIDTH-1:0] v);
        logic sx;
        sx = (SIGNED != 0) && v[WEIGHT_WIDTH-1];
        return {{(P-WEIGHT_WIDTH){sx}}, v};
    endfunction

    function automatic logic [P-1:0] ext_a(input logic [ACTIVATION_WIDTH-1:0] v);
        logic sx;
        sx = (SIGNED != 0) && v[ACTIVATION_WIDTH-1];
        return {{(P-ACTIVATION_WIDTH){sx}}, v};
    endfunction

    // During RUN the pattern counter replaces the ports so the real multiplier is exercised.
    always_comb begin
        if (state_q == RUN) begin
            w_sel  = ~WEIGHT_WIDTH'(cnt_q);
            a_sel  = ACTIVATION_WIDTH'(cnt_q);
            ps_sel = P'(cnt_q);
        end else begin
            w_sel  = active_q;
            a_sel  = activation;
            ps_sel = partial_sum_in;
        end
        mac_d = ext_w(w_sel) * ext_a(a_sel) + ps_sel;
    end

    assign fold_d = {sig_q[P-2:0], sig_q[P-1]} ^ mac_d ^ {{(P-1){1'b0}}, test_fault_inj};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (test_start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        sig_q   <= '0;
                        fail_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    sig_q <= fold_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(TEST_LEN - 1)) state_q <= CHECK;
                end
                CHECK: begin
                    fail_q  <= (sig_q != GOLDEN_SIG);
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Commit samples the shadow before this cycle's shift lands, giving pre-shift semantics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            act_q    <= '0;
            avld_q   <= 1'b0;
            pvld_q   <= 1'b0;
            psum_q   <= '0;
        end else if (busy_q) begin
            avld_q <= 1'b0;
            pvld_q <= 1'b0;
        end else begin
            if (weight_commit)   active_q <= shadow_q;
            if (weight_shift_en) shadow_q <= weight_in;
            act_q  <= activation;
            avld_q <= act_valid_in;
            pvld_q <= act_valid_in;
            if (act_valid_in) psum_q <= fault_bypass ? partial_sum_in : mac_d;
        end
    end

    assign weight_out      = shadow_q;
    assign activation_out  = act_q;
    assign act_valid_out   = avld_q;
    assign partial_sum_out = psum_q;
    assign psum_valid_out  = pvld_q;
    assign test_busy       = busy_q;
    assign test_done       = done_q;
    assign test_fail       = fail_q;

endmodule

// File: tb/tb_strait_pe_ws.sv
// Scoreboard bench for strait_pe_ws: unsigned instance fully checked, signed instance
// shares the stimulus for the two's-complement corner case.
module tb_strait_pe_ws;

    localparam int P = 19;

    function automatic logic [18:0] ref_mac(input logic [7:0] w, input logic [7:0] a,
                                            input logic [18:0] ps, input bit sg);
        int wv, av, r;
        wv = sg ? int'($signed(w)) : int'(w);
        av = sg ? int'($signed(a)) : int'(a);
        r  = wv * av + int'(ps);
        return r[18:0];
    endfunction

    function automatic logic [18:0] ref_sig();
        logic [18:0] s;
        logic [7:0]  kb;
        s = '0;
        for (int k = 0; k < 16; k++) begin
            kb = 8'(k);
            s  = {s[17:0], s[18]} ^ ref_mac(~kb, kb, 19'(k), 1'b0);
        end
        return s;
    endfunction

    localparam logic [18:0] GOLD_U = ref_sig();

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  weight_in, activation;
    logic        weight_shift_en, weight_commit, act_valid_in;
    logic [18:0] partial_sum_in;
    logic        fault_bypass, test_start, test_fault_inj;

    logic [7:0]  weight_out, activation_out, s_weight_out, s_activation_out;
    logic        act_valid_out, psum_valid_out, test_busy, test_done, test_fail;
    logic [18:0] partial_sum_out, s_partial_sum_out;
    logic        s_act_valid_out, s_psum_valid_out, s_test_busy, s_test_done, s_test_fail;

    always #5 clk = ~clk;

    strait_pe_ws #(.SIGNED(0), .TEST_LEN(16), .GOLDEN_SIG(GOLD_U)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .weight_in(weight_in), .weight_shift_en(weight_shift_en), .weight_commit(weight_commit),
        .weight_out(weight_out),
        .activation(activation), .act_valid_in(act_valid_in),
        .activation_out(activation_out), .act_valid_out(act_valid_out),
        .partial_sum_in(partial_sum_in), .partial_sum_out(partial_sum_out),
        .psum_valid_out(psum_valid_out),
        .fault_bypass(fault_bypass), .test_start(test_start), .test_fault_inj(test_fault_inj),
        .test_busy(test_busy), .test_done(test_done), .test_fail(test_fail)
    );

    strait_pe_ws #(.SIGNED(1), .TEST_LEN(16)) u_sdut (
        .clk(clk), .rst_n(rst_n),
        .weight_in(weight_in), .weight_shift_en(weight_shift_en), .weight_commit(weight_commit),
        .weight_out(s_weight_out),
        .activation(activation), .act_valid_in(act_valid_in),
        .activation_out(s_activation_out), .act_valid_out(s_act_valid_out),
        .partial_sum_in(partial_sum_in), .partial_sum_out(s_partial_sum_out),
        .psum_valid_out(s_psum_valid_out),
        .fault_bypass(fault_bypass), .test_start(1'b0), .test_fault_inj(1'b0),
        .test_busy(s_test_busy), .test_done(s_test_done), .test_fail(s_test_fail)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [18:0] sb[$];
    logic [7:0]  m_shadow, m_active, m_act;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [18:0] ps, input logic v,
                         input logic [7:0] win, input logic sh, input logic cm);
        activation      = a;
        partial_sum_in  = ps;
        act_valid_in    = v;
        weight_in       = win;
        weight_shift_en = sh;
        weight_commit   = cm;
        if (v) sb.push_back(fault_bypass ? ps : ref_mac(m_active, a, ps, 1'b0));
        if (cm) m_active = m_shadow;
        if (sh) m_shadow = win;
        m_act = a;
        step();
    endtask

    task automatic selftest(input logic inj, input logic exp_fail);
        logic [7:0] held_act, held_w;
        held_act        = m_act;
        held_w          = m_shadow;
        act_valid_in    = 1'b0;
        weight_shift_en = 1'b0;
        weight_commit   = 1'b0;
        test_fault_inj  = inj;
        test_start      = 1'b1;
        step();
        test_start = 1'b0;
        chk("busy_rise", test_busy, 1);
        for (int n = 1; n <= 17; n++) begin
            if (n <= 15) begin
                activation      = 8'($urandom);
                act_valid_in    = 1'b1;
                weight_in       = 8'($urandom);
                weight_shift_en = 1'b1;
                weight_commit   = 1'b1;
                test_start      = 1'(n & 1);
            end else begin
                act_valid_in    = 1'b0;
                weight_shift_en = 1'b0;
                weight_commit   = 1'b0;
                test_start      = 1'b0;
            end
            step();
            chk($sformatf("done_c%0d", n + 1), test_done, (n == 17));
        end
        chk("fail_at_done", test_fail, exp_fail);
        chk("busy_at_done", test_busy, 1);
        activation = held_act;
        step();
        chk("busy_fall", test_busy, 0);
        chk("done_fall", test_done, 0);
        chk("act_held", activation_out, held_act);
        chk("wout_held", weight_out, held_w);
        chk("fail_after", test_fail, exp_fail);
        test_fault_inj = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (test_busy) chk("busy_valid", {act_valid_out, psum_valid_out}, 0);
            if (psum_valid_out) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else chk("psum_sb", partial_sum_out, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        weight_in = '0; activation = '0; partial_sum_in = '0;
        weight_shift_en = 1'b0; weight_commit = 1'b0; act_valid_in = 1'b0;
        fault_bypass = 1'b0; test_start = 1'b0; test_fault_inj = 1'b0;
        m_shadow = '0; m_active = '0; m_act = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_psum", partial_sum_out, 0);
        chk("rst_wout", weight_out, 0);
        chk("rst_ctrl", {test_busy, test_done, test_fail, psum_valid_out, act_valid_out}, 0);
        rst_n = 1'b1;

        // weight preload chain and commit with simultaneous shift
        drive(0, 0, 0, 8'd1, 1, 0); chk("wout_1", weight_out, 1);
        drive(0, 0, 0, 8'd2, 1, 0); chk("wout_2", weight_out, 2);
        drive(0, 0, 0, 8'd3, 1, 0); chk("wout_3", weight_out, 3);
        drive(0, 0, 0, 8'd4, 1, 1); chk("wout_4", weight_out, 4);

        // MAC with active=3, then hold on invalid
        drive(8'd5, 19'd10, 1, 0, 0, 0);
        chk("mac_25", partial_sum_out, 25);
        chk("mac_pvld", psum_valid_out, 1);
        chk("mac_act", activation_out, 5);
        drive(8'd7, 19'd99, 0, 0, 0, 0);
        chk("hold_25", partial_sum_out, 25);
        chk("hold_pvld", psum_valid_out, 0);
        chk("hold_avld", act_valid_out, 0);

        for (int i = 0; i < 10; i++)
            drive(8'($urandom), 19'($urandom), 1'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom));

        // signed negative weight and unsigned wrap
        drive(0, 0, 0, 8'hFE, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(8'd3, 19'd0, 1, 0, 0, 0);
        chk("signed_neg", s_partial_sum_out, 19'h7FFFA);
        drive(0, 0, 0, 8'hFF, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(8'hFF, 19'h7FFFF, 1, 0, 0, 0);
        chk("unsigned_wrap", partial_sum_out, 19'h0FE00);

        // bypass
        fault_bypass = 1'b1;
        drive(8'h5A, 19'd1234, 1, 0, 0, 0);
        chk("byp_psum", partial_sum_out, 1234);
        chk("byp_act", activation_out, 8'h5A);
        chk("byp_avld", act_valid_out, 1);
        fault_bypass = 1'b0;
        drive(8'h11, 19'd0, 0, 0, 0, 0);

        selftest(1'b0, 1'b0);
        drive(8'd2, 19'd1, 1, 0, 0, 0);
        chk("post_test_mac", partial_sum_out, 511);

        selftest(1'b1, 1'b1);
        repeat (3) step();
        chk("fail_sticky", test_fail, 1);

        // reset in RUN
        test_start = 1'b1;
        step();
        test_start = 1'b0;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {test_busy, test_done, test_fail}, 0);
        chk("midrst_psum", partial_sum_out, 0);
        chk("midrst_wout", weight_out, 0);
        chk("midrst_act", activation_out, 0);
        m_shadow = '0; m_active = '0; m_act = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        activation = '0;
        selftest(1'b0, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/strait_pe_ws.md
Name: strait_pe_ws

Overview:
- Parametrised weight-stationary processing element for the systolic MAC array. Successor to the single-mode PE.
- Adds single-clock weight preload/commit (double-buffered), valid propagation, signed/unsigned arithmetic, fault-bypass for self-recovery, and a built-in self-test engine with signature compare.
- Tiled SYSTOLIC_SIZE x SYSTOLIC_SIZE:
  - activations flow east;
  - partial sums and the weight preload chain flow south.

Parameters:
- SYSTOLIC_SIZE, 8, array dimension; sets accumulator growth.
- WEIGHT_WIDTH, 8, weight bits.
- ACTIVATION_WIDTH, 8, activation bits.
- PARTIAL_SUM_WIDTH, WEIGHT_WIDTH+ACTIVATION_WIDTH+$clog2(SYSTOLIC_SIZE), psum bits (P).
- SIGNED, 0, 1 = two's-complement operands and psum.
- TEST_LEN, 16, self-test pattern count (>=2).
- GOLDEN_SIG, 0, expected P-bit self-test signature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- weight_in  in  WEIGHT_WIDTH  preload chain input from north.
- weight_shift_en  in  1  load weight_in into shadow register.
- weight_commit  in  1  copy shadow to active weight.
- weight_out  out  WEIGHT_WIDTH  shadow register, to south PE chain.
- activation  in  ACTIVATION_WIDTH  activation from west.
- act_valid_in  in  1  activation valid.
- activation_out  out  ACTIVATION_WIDTH  registered activation, to east.
- act_valid_out  out  1  registered valid.
- partial_sum_in  in  P  psum from north.
- partial_sum_out  out  P  registered psum, to south.
- psum_valid_out  out  1  partial_sum_out updated this cycle.
- fault_bypass  in  1  PE marked faulty: pass psum through.
- test_start  in  1  start self-test (pulse).
- test_fault_inj  in  1  verification hook: flip bit 0 of MAC result during self-test.
- test_busy  out  1  self-test running.
- test_done  out  1  one-cycle pulse at end of test.
- test_fail  out  1  signature mismatch, sticky.

Behaviour:
- Reset: all registers and outputs are 0, including shadow weight, active weight, signature and counter. FSM goes to IDLE.
- Weight path:
  - weight_shift_en: shadow <= weight_in. weight_out = shadow, so the chain has 1 cycle per PE.
  - weight_commit: active <= shadow.
  - Both asserted in the same cycle: active takes the pre-shift shadow value; shadow takes weight_in.
  - Weight ports are honoured in every mode except self-test RUN.
- MAC, combinational: mac = active*activation + partial_sum_in, width P, result mod 2^P (wraps, no saturation).
  - SIGNED=1: operands sign-extended to P before multiply/add.
  - SIGNED=0: zero-extended.
- Normal datapath, 1-cycle latency:
  - activation_out <= activation; act_valid_out <= act_valid_in; psum_valid_out <= act_valid_in.
  - act_valid_in=1: partial_sum_out <= mac. act_valid_in=0: partial_sum_out holds.
- Bypass (fault_bypass=1, not testing):
  - partial_sum_out <= partial_sum_in when act_valid_in=1.
  - Activation and valid forward unchanged.
  - Active weight is ignored.
- FSM states: IDLE, RUN, CHECK, DONE.
  - IDLE: test_start=1 -> RUN; cnt<=0, sig<=0, test_fail<=0.
  - RUN: pattern k=cnt drives the MAC instead of the ports:
    - a = k[ACTIVATION_WIDTH-1:0]
    - w = ~k[WEIGHT_WIDTH-1:0]
    - psum = k zero-extended to P
    - each cycle: sig <= {sig[P-2:0],sig[P-1]} ^ mac ^ {P-1'b0,test_fault_inj}; cnt++.
    - after the fold with cnt==TEST_LEN-1 -> CHECK.
  - CHECK: test_fail <= (sig != GOLDEN_SIG) -> DONE.
  - DONE: test_done=1 for this cycle only -> IDLE.
- Timing: start sampled at edge 0 -> test_done high in cycle TEST_LEN+2. test_busy=1 in RUN/CHECK/DONE.
- While test_busy:
  - act_valid_out=0, psum_valid_out=0.
  - activation_out, partial_sum_out and the active weight hold.
  - weight_shift_en/weight_commit and test_start are ignored.
- fault_bypass does not affect self-test; the test always exercises the real multiplier.
- test_fail stays set until the next accepted test_start or reset.
- Reset mid-test aborts to IDLE with all outputs 0.

Test Plan:
- Preload/commit: shift 1,2,3 on consecutive cycles -> weight_out 1,2,3. Then commit with simultaneous shift of 4 -> active=3, weight_out=4.
- Unsigned MAC: active=3, activation=5, psum_in=10, valid -> next cycle partial_sum_out=25, psum_valid_out=1. Valid=0 next -> output holds 25, psum_valid_out=0.
- Signed/wrap (P=19):
  - SIGNED=1, w=8'hFE, a=3, psum=0 -> 19'h7FFFA.
  - SIGNED=0, w=a=255, psum=19'h7FFFF -> 19'h0FE00.
- Bypass: fault_bypass=1, psum_in=1234, valid -> partial_sum_out=1234, activation forwarded 1 cycle later.
- Self-test pass/fail: GOLDEN_SIG set from the reference model, TEST_LEN=16 -> test_done in cycle 18, test_fail=0, no valid outputs during busy. Repeat with test_fault_inj=1 -> test_fail=1, sticky until the next test_start.
- Reset during RUN (cycle 5): test_busy, test_done and test_fail go 0 immediately. The next test_start runs the full sequence.
